// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding and instruction-word constants.
package mips_pkg;

   localparam logic [31:0] NOP_INST   = 32'h0000_0000;
   localparam int unsigned WORD_BYTES = 4;

   typedef enum logic [1:0] {
      REQ   = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, req/ack instruction-memory reads, valid/ready hand-off to the decoder,
// and redirect handling that squashes the fetch currently in flight.
module inst_fetch
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_pc,
   output logic [31:0] pc_plus4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misalign_err
);

   fetch_state_t r_state, w_state_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic [31:0]  r_req_addr, w_req_addr_nxt;
   logic [31:0]  r_inst, w_inst_nxt;
   logic [31:0]  r_inst_pc, w_inst_pc_nxt;
   logic         r_valid, w_valid_nxt;
   logic         r_err, w_err_nxt;
   logic [31:0]  w_redir_pc;
   logic [31:0]  w_pc_inc;

   assign w_redir_pc = {redirect_pc[31:2], 2'b00};
   assign w_pc_inc   = r_pc + 32'(WORD_BYTES);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= REQ;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_inst     <= NOP_INST;
         r_inst_pc  <= RESET_PC;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_req_addr <= w_req_addr_nxt;
         r_inst     <= w_inst_nxt;
         r_inst_pc  <= w_inst_pc_nxt;
         r_valid    <= w_valid_nxt;
         r_err      <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_req_addr_nxt = r_req_addr;
      w_inst_nxt     = r_inst;
      w_inst_pc_nxt  = r_inst_pc;
      w_valid_nxt    = r_valid;
      w_err_nxt      = r_err;

      if (redirect_valid) begin
         w_pc_nxt = w_redir_pc;
         if (redirect_pc[1:0] != 2'b00) w_err_nxt = 1'b1;
      end

      case (r_state)
         REQ: begin
            if (redirect_valid) begin
               // An unacked request cannot be withdrawn; park its address and wait it out.
               if (!imem_ack) begin
                  w_state_nxt    = DRAIN;
                  w_req_addr_nxt = r_pc;
               end
            end else if (imem_ack) begin
               w_inst_nxt    = imem_rdata;
               w_inst_pc_nxt = r_pc;
               w_valid_nxt   = 1'b1;
               w_state_nxt   = HOLD;
            end
         end
         HOLD: begin
            if (redirect_valid || inst_ready) begin
               w_valid_nxt = 1'b0;
               w_inst_nxt  = NOP_INST;
               w_state_nxt = REQ;
               if (!redirect_valid) w_pc_nxt = w_pc_inc;
            end
         end
         DRAIN: begin
            if (imem_ack) w_state_nxt = REQ;
         end
         default: w_state_nxt = REQ;
      endcase
   end

   assign imem_req     = (r_state != HOLD);
   assign imem_addr    = (r_state == DRAIN) ? r_req_addr : r_pc;
   assign inst         = r_inst;
   assign inst_valid   = r_valid;
   assign inst_pc      = r_inst_pc;
   assign pc_plus4     = r_inst_pc + 32'(WORD_BYTES);
   assign misalign_err = r_err;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic checked against a
// transaction-level model of the fetch unit.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ack, inst_valid, inst_ready, redirect_valid, misalign_err;
   logic [31:0] imem_addr, imem_rdata, inst, inst_pc, pc_plus4, redirect_pc;

   logic        w_rst, w_req, w_ack, w_valid, w_ready, w_rv, w_err;
   logic [31:0] w_addr, w_rdata, w_inst, w_ipc, w_pp4, w_rpc;

   int n_vec = 0;
   int n_err = 0;

   // Model: when no instruction is held the unit is requesting; m_drop marks a
   // request whose data is to be thrown away, issued at m_raddr.
   logic [31:0] m_pc, m_raddr, m_inst, m_ipc;
   logic        m_vld, m_drop, m_err;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .misalign_err(misalign_err)
   );

   inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata), .inst(w_inst), .inst_valid(w_valid),
      .inst_ready(w_ready), .inst_pc(w_ipc), .pc_plus4(w_pp4),
      .redirect_valid(w_rv), .redirect_pc(w_rpc), .misalign_err(w_err)
   );

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {~a[17:2], a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   function automatic void model_step();
      logic [31:0] tgt;
      tgt = {redirect_pc[31:2], 2'b00};
      if (rst) begin
         m_pc = 32'h0; m_raddr = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
         m_vld = 1'b0; m_drop = 1'b0; m_err = 1'b0;
      end else begin
         if (redirect_valid && redirect_pc[1:0] != 2'b00) m_err = 1'b1;
         if (m_vld) begin
            if (redirect_valid) begin
               m_vld = 1'b0; m_inst = 32'h0; m_pc = tgt;
            end else if (inst_ready) begin
               m_vld = 1'b0; m_inst = 32'h0; m_pc = m_pc + 32'd4;
            end
         end else begin
            if (imem_ack) begin
               if (!m_drop && !redirect_valid) begin
                  m_vld = 1'b1; m_inst = imem_rdata; m_ipc = m_pc;
               end
               m_drop = 1'b0;
            end else if (redirect_valid && !m_drop) begin
               m_raddr = m_pc; m_drop = 1'b1;
            end
            if (redirect_valid) m_pc = tgt;
         end
      end
   endfunction

   // Apply one cycle of inputs to the main DUT and advance the model; returns at the next negedge.
   task automatic drive(input logic a, input logic [31:0] d, input logic rdy,
                        input logic rv, input logic [31:0] rp);
      imem_ack = a; imem_rdata = d; inst_ready = rdy; redirect_valid = rv; redirect_pc = rp;
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL reset_req got %b want 1", imem_req); end
      n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", imem_addr); end
      n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
      n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst got %h want 0", inst); end
      n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", misalign_err); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] d;
      int k = 0;
      for (int c = 0; c < 6; c++) begin
         n_vec++;
         if (imem_req !== ((c % 2) == 0)) begin
            n_err++; $display("FAIL zw_req c=%0d got %b want %b", c, imem_req, (c % 2) == 0);
         end
         if ((c % 2) == 0) begin
            n_vec++;
            if (imem_addr !== 32'(4 * (c / 2))) begin
               n_err++; $display("FAIL zw_addr c=%0d got %h want %h", c, imem_addr, 32'(4 * (c / 2)));
            end
         end
         if (c == 1) begin
            n_vec++;
            if (inst_valid !== 1'b1 || inst !== 32'h2008_0005 || inst_pc !== 32'h0 || pc_plus4 !== 32'h4) begin
               n_err++; $display("FAIL zw_first got v=%b %h pc=%h p4=%h want 1 20080005 0 4",
                                 inst_valid, inst, inst_pc, pc_plus4);
            end
         end
         if (c == 3) begin
            n_vec++;
            if (inst_valid !== 1'b1 || inst !== 32'h0 || inst_pc !== 32'h4) begin
               n_err++; $display("FAIL zw_second got v=%b %h pc=%h want 1 0 4", inst_valid, inst, inst_pc);
            end
         end
         d = (k == 0) ? 32'h2008_0005 : (k == 1) ? 32'h0 : memf(imem_addr);
         if (imem_req) k++;
         drive(imem_req, d, 1'b1, 1'b0, 32'h0);
      end
   endtask

   task automatic test_backpressure();
      n_vec++; if (imem_addr !== 32'hC) begin n_err++; $display("FAIL bp_addr got %h want c", imem_addr); end
      drive(1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== 32'hCAFE_0001 || inst_pc !== 32'hC) begin
            n_err++; $display("FAIL bp_hold i=%0d got v=%b req=%b %h pc=%h want 1 0 cafe0001 c",
                              i, inst_valid, imem_req, inst, inst_pc);
         end
         drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
         n_err++; $display("FAIL bp_release got req=%b addr=%h v=%b want 1 10 0", imem_req, imem_addr, inst_valid);
      end
   endtask

   task automatic test_redirect_wait();
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0 || inst !== 32'h0) begin
            n_err++; $display("FAIL rw_drain i=%0d got req=%b addr=%h v=%b %h want 1 10 0 0",
                              i, imem_req, imem_addr, inst_valid, inst);
         end
         drive(i == 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      end
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0 || inst !== 32'h0) begin
         n_err++; $display("FAIL rw_target got req=%b addr=%h v=%b %h want 1 100 0 0",
                           imem_req, imem_addr, inst_valid, inst);
      end
      drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (inst_valid !== 1'b1 || inst !== 32'h1111_1111 || inst_pc !== 32'h100) begin
         n_err++; $display("FAIL rw_fetch got v=%b %h pc=%h want 1 11111111 100", inst_valid, inst, inst_pc);
      end
   endtask

   task automatic test_redirect_collide();
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (imem_addr !== 32'h104) begin n_err++; $display("FAIL rc_next got %h want 104", imem_addr); end
      drive(1'b1, 32'h2222_2222, 1'b0, 1'b1, 32'h200);
      n_vec++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200 || inst !== 32'h0) begin
         n_err++; $display("FAIL rc_ack got v=%b req=%b addr=%h %h want 0 1 200 0",
                           inst_valid, imem_req, imem_addr, inst);
      end
      drive(1'b1, 32'h3333_3333, 1'b0, 1'b0, 32'h0);
      n_vec++;
      if (inst_valid !== 1'b1 || inst !== 32'h3333_3333) begin
         n_err++; $display("FAIL rc_fetch got v=%b %h want 1 33333333", inst_valid, inst);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
      n_vec++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300 || misalign_err !== 1'b0) begin
         n_err++; $display("FAIL rc_ready got v=%b req=%b addr=%h err=%b want 0 1 300 0",
                           inst_valid, imem_req, imem_addr, misalign_err);
      end
   endtask

   task automatic test_misalign();
      drive(1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h102);
      n_vec++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100 || misalign_err !== 1'b1 || inst_valid !== 1'b0) begin
         n_err++; $display("FAIL ma_target got req=%b addr=%h err=%b v=%b want 1 100 1 0",
                           imem_req, imem_addr, misalign_err, inst_valid);
      end
      for (int i = 0; i < 4; i++) begin
         drive(imem_req, memf(imem_addr), 1'b1, 1'b0, 32'h0);
         n_vec++;
         if (misalign_err !== 1'b1) begin n_err++; $display("FAIL ma_sticky i=%0d got %b want 1", i, misalign_err); end
      end
      rst = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
      n_vec++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL ma_clear got %b want 0", misalign_err); end
   endtask

   task automatic test_random();
      int wait_left = -1;
      logic a, rv;
      logic [31:0] rp;
      for (int c = 0; c < 600; c++) begin
         n_vec++;
         if (imem_req !== !m_vld) begin n_err++; $display("FAIL rnd_req c=%0d got %b want %b", c, imem_req, !m_vld); end
         if (!m_vld) begin
            n_vec++;
            if (imem_addr !== (m_drop ? m_raddr : m_pc)) begin
               n_err++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_addr, m_drop ? m_raddr : m_pc);
            end
         end
         n_vec++;
         if (inst_valid !== m_vld || inst !== m_inst) begin
            n_err++; $display("FAIL rnd_inst c=%0d got v=%b %h want %b %h", c, inst_valid, inst, m_vld, m_inst);
         end
         if (m_vld) begin
            n_vec++;
            if (inst_pc !== m_ipc || pc_plus4 !== m_ipc + 32'd4) begin
               n_err++; $display("FAIL rnd_pc c=%0d got %h/%h want %h/%h", c, inst_pc, pc_plus4, m_ipc, m_ipc + 32'd4);
            end
         end
         n_vec++;
         if (misalign_err !== m_err) begin n_err++; $display("FAIL rnd_err c=%0d got %b want %b", c, misalign_err, m_err); end

         rst = ($urandom_range(0, 149) == 0);
         a = 1'b0;
         if (imem_req) begin
            if (wait_left < 0) wait_left = $urandom_range(0, 3);
            a = (wait_left == 0);
            wait_left = a ? -1 : wait_left - 1;
         end
         if (rst) wait_left = -1;
         rv = ($urandom_range(0, 7) == 0);
         rp = $urandom;
         if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
         drive(a, memf(imem_addr), ($urandom_range(0, 2) != 0), rv, rp);
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap_reset();
      w_rst = 1'b1;
      @(posedge clk); @(negedge clk);
      w_rst = 1'b0;
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0) begin
         n_err++; $display("FAIL wr_reset got req=%b addr=%h v=%b want 1 fffffffc 0", w_req, w_addr, w_valid);
      end
      w_ack = 1'b1; w_rdata = 32'hABCD_0000;
      @(posedge clk); @(negedge clk);
      w_ack = 1'b0;
      n_vec++;
      if (w_valid !== 1'b1 || w_inst !== 32'hABCD_0000 || w_ipc !== 32'hFFFF_FFFC || w_pp4 !== 32'h0) begin
         n_err++; $display("FAIL wr_fetch got v=%b %h pc=%h p4=%h want 1 abcd0000 fffffffc 0",
                           w_valid, w_inst, w_ipc, w_pp4);
      end
      w_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      w_ready = 1'b0;
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== 32'h0) begin
         n_err++; $display("FAIL wr_wrap got req=%b addr=%h want 1 0", w_req, w_addr);
      end
      w_rv = 1'b1; w_rpc = 32'h40;
      @(posedge clk); @(negedge clk);
      w_rv = 1'b0;
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== 32'h0) begin
         n_err++; $display("FAIL wr_drain got req=%b addr=%h want 1 0", w_req, w_addr);
      end
      w_rst = 1'b1;
      @(posedge clk); @(negedge clk);
      w_rst = 1'b0;
      n_vec++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC || w_valid !== 1'b0 || w_inst !== 32'h0) begin
         n_err++; $display("FAIL wr_midreset got req=%b addr=%h v=%b %h want 1 fffffffc 0 0",
                           w_req, w_addr, w_valid, w_inst);
      end
      @(posedge clk); @(negedge clk);
      n_vec++;
      if (w_addr !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wr_after got addr=%h want fffffffc", w_addr);
      end
   endtask

   initial begin
      rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      w_rst = 1'b1; w_ack = 1'b0; w_rdata = 32'h0; w_ready = 1'b0; w_rv = 1'b0; w_rpc = 32'h0;
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_redirect_wait();
      test_redirect_collide();
      test_misalign();
      test_random();
      test_wrap_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
